// File: rtl/MipsDefinitions.sv
// Shared MIPS pipeline types: exception codes and the IF/ID pipeline register bundle.
package MipsDefinitions;

    localparam int INSTR_ID_WIDTH = 16;

    typedef enum logic [3:0] {
        EXCEPTION_NONE    = 4'd0,
        EXCEPTION_INT     = 4'd1,
        EXCEPTION_ADEL    = 4'd2,
        EXCEPTION_ADES    = 4'd3,
        EXCEPTION_SYSCALL = 4'd4,
        EXCEPTION_BREAK   = 4'd5,
        EXCEPTION_RI      = 4'd6,
        EXCEPTION_OV      = 4'd7
    } ExceptionType;

    typedef struct packed {
        logic                      valid0;
        logic                      valid1;
        logic [31:0]               pc0;
        logic [31:0]               pc1;
        logic [31:0]               instruction0;
        logic [31:0]               instruction1;
        ExceptionType              exception0;
        ExceptionType              exception1;
        logic [INSTR_ID_WIDTH-1:0] instr_id0;
        logic [INSTR_ID_WIDTH-1:0] instr_id1;
    } IF_ID_Register;

endpackage

// File: rtl/instruction_fetch_stage.sv
// Dual-slot fetch stage: reads PC and PC+4 each cycle into the IF/ID bundle,
// owns the fetch PC and applies stalls, flushes, redirects and misaligned-fetch halts.
module instruction_fetch_stage
    import MipsDefinitions::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ID_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          jump_enable,
    input  logic [31:0]   jump_addr,
    input  logic          single_issue,
    output logic [31:0]   imem_addr0,
    output logic [31:0]   imem_addr1,
    input  logic [31:0]   imem_data0,
    input  logic [31:0]   imem_data1,
    input  logic          imem_ready,
    output IF_ID_Register if_id_reg,
    output logic [31:0]   fetch_pc
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [ID_WIDTH-1:0] CTR_ONE = ID_WIDTH'(1);
    localparam logic [ID_WIDTH-1:0] CTR_TWO = ID_WIDTH'(2);

    state_t              state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [ID_WIDTH-1:0] ctr_q, ctr_d;
    IF_ID_Register       if_id_q, if_id_d;

    assign imem_addr0 = fetch_pc_q;
    assign imem_addr1 = fetch_pc_q + 32'd4;
    assign if_id_reg  = if_id_q;
    assign fetch_pc   = fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ctr_d      = ctr_q;
        if_id_d    = if_id_q;

        // A stall freezes everything, including a pending redirect.
        if (!stall) begin
            if (jump_enable) begin
                fetch_pc_d = jump_addr;
                if_id_d    = '0;
                state_d    = RUN;
            end else if (single_issue) begin
                fetch_pc_d = if_id_q.pc1;
                if_id_d    = '0;
                state_d    = RUN;
            end else if (flush || (state_q == HALT) || !imem_ready) begin
                if_id_d = '0;
            end else if (fetch_pc_q[1:0] != 2'b00) begin
                if_id_d            = '0;
                if_id_d.valid0     = 1'b1;
                if_id_d.pc0        = fetch_pc_q;
                if_id_d.exception0 = EXCEPTION_ADEL;
                if_id_d.instr_id0  = ctr_q;
                ctr_d              = ctr_q + CTR_ONE;
                state_d            = HALT;
            end else begin
                if_id_d.valid0       = 1'b1;
                if_id_d.valid1       = 1'b1;
                if_id_d.pc0          = fetch_pc_q;
                if_id_d.pc1          = fetch_pc_q + 32'd4;
                if_id_d.instruction0 = imem_data0;
                if_id_d.instruction1 = imem_data1;
                if_id_d.exception0   = EXCEPTION_NONE;
                if_id_d.exception1   = EXCEPTION_NONE;
                if_id_d.instr_id0    = ctr_q;
                if_id_d.instr_id1    = ctr_q + CTR_ONE;
                fetch_pc_d           = fetch_pc_q + 32'd8;
                ctr_d                = ctr_q + CTR_TWO;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            ctr_q      <= '0;
            if_id_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            ctr_q      <= ctr_d;
            if_id_q    <= if_id_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: a per-cycle reference model of the fetch
// rules checked on every falling edge, plus literal expectations at key points.
module tb_instruction_fetch_stage;
    import MipsDefinitions::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          jump_enable = 1'b0;
    logic [31:0]   jump_addr = 32'h0;
    logic          single_issue = 1'b0;
    logic          imem_ready = 1'b1;
    logic [31:0]   imem_addr0, imem_addr1, imem_data0, imem_data1, fetch_pc;
    IF_ID_Register if_id_reg;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit verbose = 1'b1;

    IF_ID_Register m_b;
    logic [31:0]   m_pc;
    logic [15:0]   m_ctr;
    bit            m_halt;

    always #5 clk = ~clk;

    // Memory returns the word equal to its address.
    assign imem_data0 = imem_addr0;
    assign imem_data1 = imem_addr1;

    instruction_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .jump_enable(jump_enable), .jump_addr(jump_addr), .single_issue(single_issue),
        .imem_addr0(imem_addr0), .imem_addr1(imem_addr1),
        .imem_data0(imem_data0), .imem_data1(imem_data1), .imem_ready(imem_ready),
        .if_id_reg(if_id_reg), .fetch_pc(fetch_pc)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0000_3000;
        m_b    = '0;
        m_ctr  = 16'd0;
        m_halt = 1'b0;
    endtask

    // Expected state after the coming rising edge, from the current inputs.
    task automatic model_next();
        if (rst) begin
            model_reset();
        end else if (stall) begin
            m_pc = m_pc;
        end else if (jump_enable || single_issue) begin
            m_pc   = jump_enable ? jump_addr : m_b.pc1;
            m_b    = '0;
            m_halt = 1'b0;
        end else if (flush || m_halt || !imem_ready) begin
            m_b = '0;
        end else if ((m_pc & 32'h3) != 0) begin
            m_b            = '0;
            m_b.valid0     = 1'b1;
            m_b.pc0        = m_pc;
            m_b.exception0 = EXCEPTION_ADEL;
            m_b.instr_id0  = m_ctr;
            m_ctr          = m_ctr + 16'd1;
            m_halt         = 1'b1;
        end else begin
            m_b.valid0       = 1'b1;
            m_b.valid1       = 1'b1;
            m_b.pc0          = m_pc;
            m_b.pc1          = m_pc + 32'd4;
            m_b.instruction0 = m_pc;
            m_b.instruction1 = m_pc + 32'd4;
            m_b.exception0   = EXCEPTION_NONE;
            m_b.exception1   = EXCEPTION_NONE;
            m_b.instr_id0    = m_ctr;
            m_b.instr_id1    = m_ctr + 16'd1;
            m_pc             = m_pc + 32'd8;
            m_ctr            = m_ctr + 16'd2;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("if_id_reg", 256'(if_id_reg), 256'(m_b));
            chk("fetch_pc", 256'(fetch_pc), 256'(m_pc));
            chk("imem_addr0", 256'(imem_addr0), 256'(m_pc));
            chk("imem_addr1", 256'(imem_addr1), 256'(m_pc + 32'd4));
        end
    end

    task automatic cycle(input bit j, input logic [31:0] ja, input bit si,
                         input bit st, input bit fl, input bit rdy);
        jump_enable  = j;
        jump_addr    = ja;
        single_issue = si;
        stall        = st;
        flush        = fl;
        imem_ready   = rdy;
        model_next();
        @(negedge clk);
        #1;
        if (verbose)
            $display("t=%0t fetch_pc=%h v=%b%b pc0=%h pc1=%h exc0=%0d ids=%0d/%0d",
                     $time, fetch_pc, if_id_reg.valid0, if_id_reg.valid1, if_id_reg.pc0,
                     if_id_reg.pc1, if_id_reg.exception0, if_id_reg.instr_id0,
                     if_id_reg.instr_id1);
    endtask

    task automatic run(); cycle(0, 32'h0, 0, 0, 0, 1); endtask
    task automatic jump(input logic [31:0] a); cycle(1, a, 0, 0, 0, 1); endtask

    initial begin
        rst = 1'b1;
        model_reset();
        cmp_en = 1'b1;
        @(negedge clk);
        #1;
        chk("reset fetch_pc", 256'(fetch_pc), 256'(32'h3000));
        chk("reset imem_addr1", 256'(imem_addr1), 256'(32'h3004));
        chk("reset if_id", 256'(if_id_reg), 256'(0));
        rst = 1'b0;

        run();
        chk("first pc0", 256'(if_id_reg.pc0), 256'(32'h3000));
        chk("first pc1", 256'(if_id_reg.pc1), 256'(32'h3004));
        chk("first ids", 256'({if_id_reg.instr_id0, if_id_reg.instr_id1}), 256'(32'h0000_0001));
        run();
        chk("second pc0", 256'(if_id_reg.pc0), 256'(32'h3008));
        chk("second id1", 256'(if_id_reg.instr_id1), 256'(16'd3));
        chk("pc before jump", 256'(fetch_pc), 256'(32'h3010));

        jump(32'h3100);
        chk("jump bubble", 256'({if_id_reg.valid0, if_id_reg.valid1}), 256'(2'b00));
        run();
        chk("jump target pc0", 256'(if_id_reg.pc0), 256'(32'h3100));
        chk("jump target pc1", 256'(if_id_reg.pc1), 256'(32'h3104));
        chk("jump ids", 256'(if_id_reg.instr_id0), 256'(16'd4));

        jump(32'h3020);
        run();
        chk("pre single pc1", 256'(if_id_reg.pc1), 256'(32'h3024));
        cycle(0, 32'h0, 1, 0, 0, 1);
        chk("single bubble", 256'(if_id_reg.valid0), 256'(1'b0));
        run();
        chk("refetch pc0", 256'(if_id_reg.pc0), 256'(32'h3024));
        chk("refetch pc1", 256'(if_id_reg.pc1), 256'(32'h3028));

        for (int i = 0; i < 3; i++) cycle(1, 32'h3500, 0, 1, 0, 1);
        chk("stall pc0 held", 256'(if_id_reg.pc0), 256'(32'h3024));
        chk("stall fetch_pc held", 256'(fetch_pc), 256'(32'h302C));
        cycle(0, 32'h0, 0, 0, 1, 1);
        chk("flush fetch_pc", 256'(fetch_pc), 256'(32'h302C));
        run();
        chk("after flush pc0", 256'(if_id_reg.pc0), 256'(32'h302C));

        cycle(0, 32'h0, 0, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0, 0);
        chk("backpressure pc", 256'(fetch_pc), 256'(32'h3034));
        run();
        chk("resume ids", 256'(if_id_reg.instr_id0), 256'(16'd12));

        cycle(1, 32'h3040, 1, 0, 0, 1);
        chk("jump beats single", 256'(fetch_pc), 256'(32'h3040));
        run();

        jump(32'h3102);
        run();
        chk("adel valid", 256'({if_id_reg.valid0, if_id_reg.valid1}), 256'(2'b10));
        chk("adel exc", 256'(if_id_reg.exception0), 256'(EXCEPTION_ADEL));
        chk("adel id", 256'(if_id_reg.instr_id0), 256'(16'd16));
        run();
        run();
        cycle(1, 32'h3300, 0, 1, 0, 1);
        chk("halt+stall pc", 256'(fetch_pc), 256'(32'h3102));
        jump(32'h3200);
        run();
        chk("halt exit pc0", 256'(if_id_reg.pc0), 256'(32'h3200));
        chk("halt exit id0", 256'(if_id_reg.instr_id0), 256'(16'd17));

        verbose = 1'b0;
        for (int i = 0; i < 40000 && m_ctr != 16'hFFFF; i++) run();
        verbose = 1'b1;
        run();
        chk("id wrap", 256'({if_id_reg.instr_id0, if_id_reg.instr_id1}), 256'(32'hFFFF_0000));

        jump(32'hFFFF_FFF8);
        run();
        chk("pc wrap pc1", 256'(if_id_reg.pc1), 256'(32'hFFFF_FFFC));
        chk("pc wrap fetch", 256'(fetch_pc), 256'(32'h0));

        jump(32'h3001);
        run();
        run();
        rst = 1'b1;
        #1;
        chk("async rst if_id", 256'(if_id_reg), 256'(0));
        chk("async rst pc", 256'(fetch_pc), 256'(32'h3000));
        model_reset();
        cycle(0, 32'h0, 0, 0, 0, 1);
        rst = 1'b0;
        run();
        chk("post rst ids", 256'({if_id_reg.instr_id0, if_id_reg.instr_id1}), 256'(32'h0000_0001));
        chk("post rst pc0", 256'(if_id_reg.pc0), 256'(32'h3000));

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
